// File: rtl/recovery_controller.sv
// Misprediction recovery sequencer: stalls issue, drains committed stores,
// squashes the back end, clears regstat tags and redirects fetch.
module recovery_controller #(
  parameter int FLUSH_CYCLES  = 2,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mispredict_in,
  input  logic [31:0] target_pc,
  input  logic        store_pending,
  output logic        flush,
  output logic        regstat_clear,
  output logic        issue_stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        drain_timeout,
  output logic [15:0] recover_count
);

  localparam int MAXC =
    (FLUSH_CYCLES > DRAIN_TIMEOUT) ? FLUSH_CYCLES : DRAIN_TIMEOUT;
  localparam int CW = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    REDIRECT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   pc_n;
  logic          timeout_n;
  logic [15:0]   count_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      redirect_pc   <= '0;
      drain_timeout <= 1'b0;
      recover_count <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      redirect_pc   <= pc_n;
      drain_timeout <= timeout_n;
      recover_count <= count_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pc_n      = redirect_pc;
    timeout_n = drain_timeout;
    count_n   = recover_count;
    unique case (state)
      IDLE: begin
        if (mispredict_in) begin
          pc_n    = target_pc;
          cnt_n   = '0;
          state_n = store_pending ? DRAIN : FLUSH;
        end
      end
      DRAIN: begin
        // A store finishing on the last allowed cycle is not a timeout
        if (!store_pending) begin
          state_n = FLUSH;
          cnt_n   = '0;
        end else if (cnt == DRAIN_LAST) begin
          timeout_n = 1'b1;
          state_n   = FLUSH;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      FLUSH: begin
        if (cnt == FLUSH_LAST) begin
          state_n = REDIRECT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      REDIRECT: begin
        state_n = IDLE;
        if (recover_count != 16'hFFFF)
          count_n = recover_count + 16'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign flush          = (state == FLUSH);
  assign regstat_clear  = (state == FLUSH) && (cnt == '0);
  assign redirect_valid = (state == REDIRECT);
  assign issue_stall    = (state != IDLE);

endmodule

// File: tb/tb_recovery_controller.sv
// Directed bench for recovery_controller with FLUSH_CYCLES=2,
// DRAIN_TIMEOUT=8 and hand-computed per-cycle expectations.
module tb_recovery_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        mispredict_in;
  logic [31:0] target_pc;
  logic        store_pending;
  logic        flush;
  logic        regstat_clear;
  logic        issue_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        drain_timeout;
  logic [15:0] recover_count;

  int checks = 0;
  int errors = 0;

  recovery_controller #(
    .FLUSH_CYCLES (2),
    .DRAIN_TIMEOUT(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mispredict_in (mispredict_in),
    .target_pc     (target_pc),
    .store_pending (store_pending),
    .flush         (flush),
    .regstat_clear (regstat_clear),
    .issue_stall   (issue_stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .drain_timeout (drain_timeout),
    .recover_count (recover_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flush, regstat_clear, redirect_valid, issue_stall
  task automatic expect_out(input string tag, input logic [3:0] e);
    check({tag, ".flush"}, 32'(flush), 32'(e[3]));
    check({tag, ".rclr"},  32'(regstat_clear), 32'(e[2]));
    check({tag, ".redir"}, 32'(redirect_valid), 32'(e[1]));
    check({tag, ".stall"}, 32'(issue_stall), 32'(e[0]));
  endtask

  initial begin
    reset         = 1'b1;
    mispredict_in = 1'b1;
    target_pc     = 32'hDEAD_BEEF;
    store_pending = 1'b0;
    tick();
    tick();
    expect_out("rst", 4'b0000);
    check("rst.pc",  redirect_pc, 32'h0);
    check("rst.to",  32'(drain_timeout), 32'h0);
    check("rst.cnt", 32'(recover_count), 32'h0);

    reset         = 1'b0;
    mispredict_in = 1'b0;
    tick();
    tick();
    expect_out("idle", 4'b0000);

    // Basic recovery; cycle 2 carries an ignored mispredict,
    // cycle 4 a back-to-back one accepted from IDLE.
    mispredict_in = 1'b1;
    target_pc     = 32'h0000_0040;
    tick();
    mispredict_in = 1'b0;
    expect_out("b1", 4'b1101);
    tick();
    expect_out("b2", 4'b1001);
    mispredict_in = 1'b1;
    target_pc     = 32'h0000_0080;
    tick();
    mispredict_in = 1'b0;
    expect_out("b3", 4'b0011);
    check("b3.pc", redirect_pc, 32'h40);
    tick();
    expect_out("b4", 4'b0000);
    check("b4.cnt", 32'(recover_count), 32'd1);
    mispredict_in = 1'b1;
    target_pc     = 32'h0000_0100;
    tick();
    mispredict_in = 1'b0;
    expect_out("bb5", 4'b1101);
    tick();
    expect_out("bb6", 4'b1001);
    tick();
    expect_out("bb7", 4'b0011);
    check("bb7.pc", redirect_pc, 32'h100);
    tick();
    check("bb8.cnt", 32'(recover_count), 32'd2);
    check("bb8.stall", 32'(issue_stall), 32'h0);

    // Store drain lasting 5 cycles
    mispredict_in = 1'b1;
    target_pc     = 32'h0000_0200;
    store_pending = 1'b1;
    tick();
    mispredict_in = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      expect_out($sformatf("d%0d", c), 4'b0001);
      if (c == 5) store_pending = 1'b0;
      tick();
    end
    expect_out("d6", 4'b1101);
    tick();
    expect_out("d7", 4'b1001);
    tick();
    expect_out("d8", 4'b0011);
    check("d8.pc", redirect_pc, 32'h200);
    check("d8.to", 32'(drain_timeout), 32'h0);
    tick();
    check("d9.cnt", 32'(recover_count), 32'd3);

    // Drain timeout: store never completes
    mispredict_in = 1'b1;
    target_pc     = 32'h0000_0300;
    store_pending = 1'b1;
    tick();
    mispredict_in = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      expect_out($sformatf("t%0d", c), 4'b0001);
      check($sformatf("t%0d.to", c), 32'(drain_timeout), 32'h0);
      tick();
    end
    expect_out("t9", 4'b1101);
    check("t9.to", 32'(drain_timeout), 32'h1);
    tick();
    expect_out("t10", 4'b1001);
    tick();
    expect_out("t11", 4'b0011);
    check("t11.pc", redirect_pc, 32'h300);
    store_pending = 1'b0;
    tick();
    tick();
    check("t13.to", 32'(drain_timeout), 32'h1);
    check("t13.cnt", 32'(recover_count), 32'd4);

    // Reset in cycle 1 of a recovery aborts it
    mispredict_in = 1'b1;
    target_pc     = 32'h0000_0400;
    tick();
    mispredict_in = 1'b0;
    expect_out("r1", 4'b1101);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_out("r2", 4'b0000);
    for (int c = 3; c <= 5; c++) begin
      tick();
      expect_out($sformatf("r%0d", c), 4'b0000);
    end
    check("r.cnt", 32'(recover_count), 32'd0);
    check("r.to",  32'(drain_timeout), 32'h0);
    check("r.pc",  redirect_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/recovery_controller.md
# recovery_controller

Misprediction recovery sequencer for the out-of-order core. On a mispredict reported by the commit unit, it stalls issue and waits for any committed store still in data memory to finish. It then broadcasts a multi-cycle squash to the RSs, LSQ, ROB, FUs and the fetch-issue register, clears the register-status tags, and hands fetch a one-cycle redirect to the correct PC. It sits between commit and the front end, replacing the raw `mispredicted` fan-out.

## Interface
Parameters:
- FLUSH_CYCLES, 2: number of cycles `flush` is held asserted; legal range ≥ 1.
- DRAIN_TIMEOUT, 64: maximum number of cycles spent waiting for store drain before a forced flush; legal range ≥ 2.

Ports:
- clk  in  1  core clock.
- reset  in  1  reset; one clock, reset is synchronous and active-high.
- mispredict_in  in  1  commit unit: the committed branch resolved opposite to its prediction; sampled only in IDLE.
- target_pc  in  32  correct next PC; captured with mispredict_in.
- store_pending  in  1  data memory: a committed store write is still in flight.
- flush  out  1  squash to RS, LSQ, ROB, FUs, fetch-issue register.
- regstat_clear  out  1  one-cycle pulse; clears all regstat ROB tags.
- issue_stall  out  1  holds fetch/issue while recovery is in progress.
- redirect_valid  out  1  one-cycle pulse to fetch.
- redirect_pc  out  32  PC to load; valid when redirect_valid = 1.
- drain_timeout  out  1  sticky error flag: a drain timeout occurred.
- recover_count  out  16  number of completed recoveries; saturating.

## Operation
- Four states: IDLE, DRAIN, FLUSH, REDIRECT. A single counter `cnt` is shared between DRAIN and FLUSH. Its width is $clog2(max(FLUSH_CYCLES, DRAIN_TIMEOUT)) + 1.
- IDLE:
  - If mispredict_in = 1, latch target_pc into redirect_pc and clear cnt.
  - Next state is DRAIN if store_pending = 1, else FLUSH.
- DRAIN:
  - If store_pending = 0, go to FLUSH. This takes priority over the timeout when both occur in the same cycle.
  - Else if cnt = DRAIN_TIMEOUT-1, set drain_timeout and go to FLUSH.
  - Else increment cnt.
  - On every exit from DRAIN, clear cnt.
- FLUSH:
  - Hold for FLUSH_CYCLES cycles: increment cnt each cycle.
  - When cnt = FLUSH_CYCLES-1, go to REDIRECT.
- REDIRECT:
  - Stays one cycle, then returns to IDLE.
  - On leaving, increment recover_count, saturating at 0xFFFF.
- mispredict_in is ignored in every state except IDLE. A younger mispredict is already squashed by the pending flush. target_pc is not re-latched.
- All outputs are Moore outputs, decoded from registered state:
  - flush = (state == FLUSH).
  - regstat_clear = FLUSH and cnt = 0.
  - redirect_valid = (state == REDIRECT).
  - issue_stall = (state != IDLE).
- In DRAIN, flush stays 0 so the in-flight committed store completes unharmed.
- redirect_pc holds its last captured value between recoveries.

## Timing
- Reset values: state IDLE; every output 0, including redirect_pc, recover_count and drain_timeout; cnt = 0.
- Reset in any state returns to IDLE on the next edge. No redirect pulse is emitted and the aborted recovery is not counted.
- No-drain latency, with mispredict_in sampled at edge 0:
  - Cycles 1..FLUSH_CYCLES: flush = 1.
  - Cycle 1: regstat_clear = 1.
  - Cycle FLUSH_CYCLES+1: redirect_valid = 1.
  - Cycle FLUSH_CYCLES+2: back in IDLE; issue_stall = 0 and recover_count has incremented.
- With drain: latency grows by the number of DRAIN cycles, D, where 1 ≤ D ≤ DRAIN_TIMEOUT.
- A mispredict_in asserted in the first IDLE cycle after REDIRECT is accepted, giving back-to-back recoveries.
- drain_timeout stays at 1 until reset.

## Test plan
- Reset: hold reset 2 cycles with mispredict_in = 1 -> all outputs 0; state stays IDLE after release until mispredict_in is sampled.
- Basic recovery, FLUSH_CYCLES = 2: mispredict_in pulse at cycle 0, target_pc = 0x0000_0040, store_pending = 0 -> flush = 1 in cycles 1-2; regstat_clear = 1 in cycle 1 only; redirect_valid = 1 with redirect_pc = 0x40 in cycle 3; issue_stall = 1 in cycles 1-3; recover_count = 1.
- Store drain: store_pending = 1 for cycles 0-5, then 0 -> DRAIN in cycles 1-5 with flush = 0 and issue_stall = 1; flush = 1 in cycles 6-7; redirect_valid = 1 in cycle 8; drain_timeout = 0.
- Timeout, DRAIN_TIMEOUT = 8: store_pending held at 1 -> 8 DRAIN cycles; drain_timeout = 1 from cycle 9; flush = 1 in cycles 9-10; redirect_valid = 1 in cycle 11; drain_timeout stays 1 afterwards.
- Ignored mispredict: second mispredict_in with target_pc = 0x80 in cycle 2 (FLUSH) -> redirect_pc stays 0x40; recover_count advances by 1. A mispredict at 0x100 in cycle 4 (IDLE) is accepted: redirect_valid = 1 with redirect_pc = 0x100 in cycle 7.
- Reset mid-FLUSH: assert reset in cycle 1 of a recovery -> flush = 0 and issue_stall = 0 from cycle 2; no redirect_valid pulse; recover_count = 0.
